voice_allocator: RTL and testbench
==================================

// Module: voice_allocator
// PURPOSE
//  Polyphonic note scheduler for a bank of NVOICES envelope_generator voices.
//  Accepts note-on/off events over a valid/ready handshake and drives each voice's gate and note number.
//  Sits between the MIDI/control decoder and the per-voice oscillator+ADSR datapath.
//  Allocation priority for a note-on: free voice, then a releasing voice, then steal the oldest gated voice.
// PARAMETERS
//  NVOICES    4  number of voices managed (>=2)
//  NOTE_BITS  7  width of note number
//  AGE_BITS   8  width of allocation stamp counter (wraps)
// PORTS
//  clk          in   1                  system clock, all logic rising-edge
//  rst          in   1                  synchronous, active-high reset
//  ev_valid     in   1                  event present
//  ev_ready     out  1                  allocator can accept event (high only in IDLE)
//  ev_on        in   1                  1 = note-on, 0 = note-off
//  ev_note      in   NOTE_BITS          note number of event
//  voice_active in   NVOICES            per voice: envelope not in OFF state
//  gate         out  NVOICES            per-voice gate to envelope_generator
//  voice_note   out  NVOICES*NOTE_BITS  per-voice note, voice i at [i*NOTE_BITS +: NOTE_BITS]
//  steal        out  1                  one-cycle pulse when a gated voice was stolen
// BEHAVIOUR
//  Reset: gate=0, voice_note=0, all stamps=0, stamp counter=0, steal=0, state=IDLE, ev_ready=1.
//  rst mid-operation: in-flight event dropped, same reset values next cycle.
//  States: IDLE -> SCAN -> COMMIT -> (RETRIG) -> IDLE.
//  IDLE: ev_ready=1; ev_valid&ev_ready latches ev_on/ev_note, goes to SCAN, idx=0.
//  SCAN: examines voice idx each cycle, idx 0..NVOICES-1 (NVOICES cycles), tracking:
//   match = lowest idx with gate=1 and voice_note=ev_note; free = lowest idx with gate=0 & voice_active=0;
//   rel = lowest idx with gate=0 & voice_active=1; old = max age, age=(stamp_cnt-stamp[i]) mod 2^AGE_BITS,
//   ties -> lowest idx.
//  COMMIT, note-off: gate<=0 on every voice with gate=1 & matching note; no match -> no change. -> IDLE.
//  COMMIT, note-on: target = match ? match : free ? free : rel ? rel : old.
//   voice_note[target]<=ev_note, stamp[target]<=stamp_cnt, stamp_cnt<=stamp_cnt+1 (wraps).
//   If target was gated (match or steal): gate[target]<=0, go RETRIG; steal=1 this cycle only if stolen (not match).
//   Else gate[target]<=1, -> IDLE.
//  RETRIG: gate[target]<=1 (exactly one low cycle so envelope restarts). -> IDLE.
//  Latency: event accepted cycle 0; gate change visible cycle NVOICES+2; ev_ready high again cycle NVOICES+2
//   (NVOICES+3 via RETRIG).
//  Events arriving while ev_ready=0 are back-pressured, never lost.
//  Gates of voices not targeted never change except by note-off/pedal.
//  voice_active is sampled during SCAN only; changes after its voice is scanned ignored for that event.
// CONFIGURATION
//  SUSTAIN_PEDAL_EN defined: adds input pedal (1 bit) and per-voice held flag (reset 0).
//   note-off while pedal=1: matching gated voices set held=1, gate stays 1.
//   pedal falling edge (registered, in any state): gate<=0 & held<=0 for all held voices.
//   note-on retargeting a voice clears its held flag. Held voices count as gated for allocation.
//  Not defined: no pedal port, note-off always clears gate immediately in COMMIT.
// TESTING
//  reset, NVOICES=4: on 60 -> gate=0001, voice_note[0]=60 at cycle 6, ev_ready back at 6.
//  on 60,62,64,67,then 69 all voices gated -> voice0 (oldest) gate low one cycle then high,
//   note 69, steal pulse once.
//  on 60 then on 60 again -> same voice 0, gate 1->0->1 single low cycle, no steal, other gates 0.
//  on 60, off 60 with voice_active[0]=1, on 62 -> voice1 free, chosen over releasing voice0;
//   off 61 unmatched -> no change.
//  rst asserted during SCAN -> next cycle gate=0, ev_ready=1; 300 note-ons verify stamp wrap
//   still steals oldest.
//  SUSTAIN_PEDAL_EN: pedal=1, on 60, off 60 -> gate[0] stays 1; pedal 1->0 -> gate[0]=0 next cycle.

Source files
------------

// File: rtl/voice_allocator_if.sv
// Note-event handshake between the control decoder (master) and the voice allocator (slave).
interface voice_allocator_if #(
    parameter int unsigned NOTE_BITS = 7
);
    logic                 ev_valid;
    logic                 ev_ready;
    logic                 ev_on;
    logic [NOTE_BITS-1:0] ev_note;

    modport master (output ev_valid, output ev_on, output ev_note, input ev_ready);
    modport slave  (input ev_valid, input ev_on, input ev_note, output ev_ready);
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic note scheduler: allocates note-on/off events to NVOICES envelope voices.
// Priority for note-on: retrigger a matching gated voice, else free, else releasing,
// else steal the oldest gated voice.
// Optional feature: define SUSTAIN_PEDAL_EN to add the sustain pedal input and held flags.
module voice_allocator #(
    parameter int unsigned NVOICES   = 4,
    parameter int unsigned NOTE_BITS = 7,
    parameter int unsigned AGE_BITS  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    voice_allocator_if.slave             ev,
    input  logic [NVOICES-1:0]           voice_active,
`ifdef SUSTAIN_PEDAL_EN
    input  logic                         pedal,
`endif
    output logic [NVOICES-1:0]           gate,
    output logic [NVOICES*NOTE_BITS-1:0] voice_note,
    output logic                         steal
);

    localparam int unsigned IDX_BITS = (NVOICES > 1) ? $clog2(NVOICES) : 1;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NVOICES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT, RETRIG} state_t;

    state_t               state;
    logic                 ready_q;
    logic [IDX_BITS-1:0]  idx;
    logic                 ev_on_q;
    logic [NOTE_BITS-1:0] ev_note_q;
    logic                 match_found;
    logic [IDX_BITS-1:0]  match_idx;
    logic                 free_found;
    logic [IDX_BITS-1:0]  free_idx;
    logic                 rel_found;
    logic [IDX_BITS-1:0]  rel_idx;
    logic [IDX_BITS-1:0]  old_idx;
    logic [AGE_BITS-1:0]  old_age;
    logic [IDX_BITS-1:0]  target_q;
    logic [AGE_BITS-1:0]  stamp [NVOICES];
    logic [AGE_BITS-1:0]  stamp_cnt;
`ifdef SUSTAIN_PEDAL_EN
    logic [NVOICES-1:0]   held;
    logic                 pedal_q;
`endif

    logic [NOTE_BITS-1:0] scan_note_c;
    logic [AGE_BITS-1:0]  scan_age_c;
    logic [IDX_BITS-1:0]  target_c;

    assign ev.ev_ready = ready_q;

    // Per-scan-step view of the voice under examination and the note-on target choice.
    always_comb begin
        scan_note_c = voice_note[idx*NOTE_BITS +: NOTE_BITS];
        scan_age_c  = AGE_BITS'(stamp_cnt - stamp[idx]);
        if (match_found)     target_c = match_idx;
        else if (free_found) target_c = free_idx;
        else if (rel_found)  target_c = rel_idx;
        else                 target_c = old_idx;
    end

    // Allocation FSM with all outputs and voice state registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ready_q     <= 1'b1;
            idx         <= '0;
            ev_on_q     <= 1'b0;
            ev_note_q   <= '0;
            match_found <= 1'b0;
            match_idx   <= '0;
            free_found  <= 1'b0;
            free_idx    <= '0;
            rel_found   <= 1'b0;
            rel_idx     <= '0;
            old_idx     <= '0;
            old_age     <= '0;
            target_q    <= '0;
            stamp_cnt   <= '0;
            gate        <= '0;
            voice_note  <= '0;
            steal       <= 1'b0;
            for (int i = 0; i < int'(NVOICES); i++) stamp[i] <= '0;
`ifdef SUSTAIN_PEDAL_EN
            held        <= '0;
            pedal_q     <= 1'b0;
`endif
        end else begin
            steal <= 1'b0;
`ifdef SUSTAIN_PEDAL_EN
            // Pedal release drops every held voice, independent of FSM state.
            pedal_q <= pedal;
            if (pedal_q && !pedal) begin
                for (int i = 0; i < int'(NVOICES); i++) begin
                    if (held[i]) begin
                        gate[i] <= 1'b0;
                        held[i] <= 1'b0;
                    end
                end
            end
`endif
            case (state)
                IDLE: begin
                    if (ev.ev_valid) begin
                        ev_on_q     <= ev.ev_on;
                        ev_note_q   <= ev.ev_note;
                        idx         <= '0;
                        match_found <= 1'b0;
                        free_found  <= 1'b0;
                        rel_found   <= 1'b0;
                        old_idx     <= '0;
                        old_age     <= '0;
                        ready_q     <= 1'b0;
                        state       <= SCAN;
                    end
                end
                SCAN: begin
                    if (!match_found && gate[idx] && scan_note_c == ev_note_q) begin
                        match_found <= 1'b1;
                        match_idx   <= idx;
                    end
                    if (!free_found && !gate[idx] && !voice_active[idx]) begin
                        free_found <= 1'b1;
                        free_idx   <= idx;
                    end
                    if (!rel_found && !gate[idx] && voice_active[idx]) begin
                        rel_found <= 1'b1;
                        rel_idx   <= idx;
                    end
                    // Strict compare keeps the lowest index on equal ages.
                    if (idx == '0 || scan_age_c > old_age) begin
                        old_age <= scan_age_c;
                        old_idx <= idx;
                    end
                    if (idx == LAST_IDX) state <= COMMIT;
                    else                 idx   <= idx + 1'b1;
                end
                COMMIT: begin
                    if (!ev_on_q) begin
                        for (int i = 0; i < int'(NVOICES); i++) begin
                            if (gate[i] && voice_note[i*NOTE_BITS +: NOTE_BITS] == ev_note_q) begin
`ifdef SUSTAIN_PEDAL_EN
                                if (pedal) begin
                                    held[i] <= 1'b1;
                                end else begin
                                    gate[i] <= 1'b0;
                                    held[i] <= 1'b0;
                                end
`else
                                gate[i] <= 1'b0;
`endif
                            end
                        end
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        voice_note[target_c*NOTE_BITS +: NOTE_BITS] <= ev_note_q;
                        stamp[target_c] <= stamp_cnt;
                        stamp_cnt       <= stamp_cnt + 1'b1;
                        target_q        <= target_c;
`ifdef SUSTAIN_PEDAL_EN
                        held[target_c]  <= 1'b0;
`endif
                        if (gate[target_c]) begin
                            // Force one low cycle so the envelope restarts.
                            gate[target_c] <= 1'b0;
                            steal          <= !match_found;
                            state          <= RETRIG;
                        end else begin
                            gate[target_c] <= 1'b1;
                            ready_q        <= 1'b1;
                            state          <= IDLE;
                        end
                    end
                end
                RETRIG: begin
                    gate[target_q] <= 1'b1;
                    ready_q        <= 1'b1;
                    state          <= IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed self-checking bench for voice_allocator (NVOICES=4, NOTE_BITS=7, AGE_BITS=8).
module tb_voice_allocator;

    logic        clk;
    logic        rst;
    logic [3:0]  voice_active;
    logic [3:0]  gate;
    logic [27:0] voice_note;
    logic        steal;
`ifdef SUSTAIN_PEDAL_EN
    logic        pedal;
`endif

    int checks;
    int errors;
    int steal_cnt;

    voice_allocator_if #(.NOTE_BITS(7)) ev_if ();

    voice_allocator #(.NVOICES(4), .NOTE_BITS(7), .AGE_BITS(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .ev           (ev_if),
        .voice_active (voice_active),
`ifdef SUSTAIN_PEDAL_EN
        .pedal        (pedal),
`endif
        .gate         (gate),
        .voice_note   (voice_note),
        .steal        (steal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] note_of(input int v);
        return voice_note[v*7 +: 7];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ev_if.ev_valid = 1'b0;
        voice_active = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Present an event, wait (bounded) for acceptance; returns in cycle 1 after acceptance.
    task automatic send(input logic on, input logic [6:0] note);
        int n = 0;
        ev_if.ev_valid = 1'b1;
        ev_if.ev_on    = on;
        ev_if.ev_note  = note;
        while (ev_if.ev_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("accept_ready", 32'(ev_if.ev_ready), 32'd1);
        tick();
        ev_if.ev_valid = 1'b0;
        steal_cnt = 0;
    endtask

    // Wait (bounded) for the allocator to return to idle, counting steal pulses.
    task automatic wait_idle();
        int n = 0;
        while (ev_if.ev_ready !== 1'b1 && n < 20) begin
            if (steal === 1'b1) steal_cnt++;
            tick();
            n++;
        end
        check("idle_timeout", 32'(ev_if.ev_ready), 32'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        steal_cnt = 0;
        ev_if.ev_valid = 1'b0;
        ev_if.ev_on    = 1'b0;
        ev_if.ev_note  = '0;
`ifdef SUSTAIN_PEDAL_EN
        pedal = 1'b0;
`endif
        do_reset();

        // Reset values
        check("rst_gate",  32'(gate), 32'h0);
        check("rst_note",  32'(voice_note), 32'h0);
        check("rst_ready", 32'(ev_if.ev_ready), 32'd1);
        check("rst_steal", 32'(steal), 32'd0);

        // First note-on latency: gate visible and ready back at cycle 6
        send(1'b1, 7'd60);
        check("lat_c1_ready", 32'(ev_if.ev_ready), 32'd0);
        repeat (4) tick();
        check("lat_c5_gate",  32'(gate), 32'h0);
        check("lat_c5_ready", 32'(ev_if.ev_ready), 32'd0);
        tick();
        check("lat_c6_gate",  32'(gate), 32'b0001);
        check("lat_c6_note0", 32'(note_of(0)), 32'd60);
        check("lat_c6_ready", 32'(ev_if.ev_ready), 32'd1);

        // Same note again: retrigger voice 0 with a single low cycle, no steal
        send(1'b1, 7'd60);
        repeat (4) tick();
        check("rtg_c5_gate",  32'(gate), 32'b0001);
        tick();
        check("rtg_c6_gate",  32'(gate), 32'b0000);
        check("rtg_c6_steal", 32'(steal), 32'd0);
        check("rtg_c6_ready", 32'(ev_if.ev_ready), 32'd0);
        tick();
        check("rtg_c7_gate",  32'(gate), 32'b0001);
        check("rtg_c7_ready", 32'(ev_if.ev_ready), 32'd1);
        check("rtg_c7_note0", 32'(note_of(0)), 32'd60);

        // Fill all voices, then steal the oldest (voice 0)
        do_reset();
        send(1'b1, 7'd60); wait_idle();
        send(1'b1, 7'd62); wait_idle();
        send(1'b1, 7'd64); wait_idle();
        send(1'b1, 7'd67); wait_idle();
        check("fill_gate", 32'(gate), 32'b1111);
        check("fill_note3", 32'(note_of(3)), 32'd67);
        send(1'b1, 7'd69);
        repeat (4) tick();
        check("stl_c5_gate",  32'(gate), 32'b1111);
        check("stl_c5_steal", 32'(steal), 32'd0);
        tick();
        check("stl_c6_gate",  32'(gate), 32'b1110);
        check("stl_c6_steal", 32'(steal), 32'd1);
        tick();
        check("stl_c7_gate",  32'(gate), 32'b1111);
        check("stl_c7_steal", 32'(steal), 32'd0);
        check("stl_c7_ready", 32'(ev_if.ev_ready), 32'd1);
        check("stl_c7_note0", 32'(note_of(0)), 32'd69);
        check("stl_c7_note1", 32'(note_of(1)), 32'd62);

        // Free voice preferred over releasing voice; unmatched note-off is a no-op
        do_reset();
        send(1'b1, 7'd60); wait_idle();
        voice_active = 4'b0001;
        send(1'b0, 7'd60); wait_idle();
        check("off_gate", 32'(gate), 32'b0000);
        send(1'b1, 7'd62); wait_idle();
        check("free_gate",  32'(gate), 32'b0010);
        check("free_note1", 32'(note_of(1)), 32'd62);
        send(1'b0, 7'd61); wait_idle();
        check("unm_gate",  32'(gate), 32'b0010);
        check("unm_notes", 32'(voice_note), 32'({7'd0, 7'd0, 7'd62, 7'd60}));
        voice_active = 4'b1101;
        send(1'b1, 7'd64); wait_idle();
        check("rel_gate",  32'(gate), 32'b0011);
        check("rel_note0", 32'(note_of(0)), 32'd64);
        check("rel_steal", 32'(steal_cnt), 32'd0);

        // Reset during SCAN drops the in-flight event
        send(1'b1, 7'd70);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        voice_active = 4'b0000;
        check("rsc_gate",  32'(gate), 32'h0);
        check("rsc_ready", 32'(ev_if.ev_ready), 32'd1);
        check("rsc_note",  32'(voice_note), 32'h0);
        check("rsc_steal", 32'(steal), 32'd0);
        send(1'b1, 7'd5); wait_idle();
        check("rsc_after_gate",  32'(gate), 32'b0001);
        check("rsc_after_note0", 32'(note_of(0)), 32'd5);

        // 300 note-ons: round-robin steal across stamp counter wrap
        do_reset();
        for (int i = 0; i < 300; i++) begin
            logic [6:0] n;
            n = 7'(i);
            send(1'b1, n);
            wait_idle();
            check("wrap_note", 32'(note_of(i % 4)), 32'(n));
            check("wrap_gate", 32'(gate[i % 4]), 32'd1);
            check("wrap_steal", 32'(steal_cnt), (i >= 4) ? 32'd1 : 32'd0);
        end
        check("wrap_all_gate", 32'(gate), 32'b1111);

`ifdef SUSTAIN_PEDAL_EN
        // Sustain: note-off under pedal holds the gate; pedal release drops it
        do_reset();
        pedal = 1'b1;
        tick();
        send(1'b1, 7'd60); wait_idle();
        send(1'b0, 7'd60); wait_idle();
        check("ped_held_gate", 32'(gate), 32'b0001);
        tick();
        check("ped_still_gate", 32'(gate), 32'b0001);
        pedal = 1'b0;
        tick();
        check("ped_rel_gate", 32'(gate), 32'b0000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
